rm_c4_violation_collector: RTL and testbench

//  Consumes the seven per-property violation flags (ltl0c4..ltl6c4) produced by the cluster-4 automata monitor.

---
 rtl/rm_c4_violation_collector.sv | 136 +++++++++++++
 tb/tb_rm_c4_violation_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rm_c4_violation_collector.sv
// Cluster-4 violation collector: timestamps masked violation flags into a show-ahead event FIFO,
// keeps sticky status, saturating per-property hit counters and a level irq. Option: RM_C4_EDGE_DETECT_EN.
module rm_c4_violation_collector #(
    parameter int NUM_PROPS  = 7,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [NUM_PROPS-1:0]         ltl_flags,
    input  logic [NUM_PROPS-1:0]         prop_mask,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [NUM_PROPS-1:0]         evt_flags,
    output logic [TS_W-1:0]              evt_stamp,
    output logic [NUM_PROPS-1:0]         sticky,
    output logic                         overflow,
    input  logic                         clr_sticky,
    input  logic [$clog2(NUM_PROPS)-1:0] cnt_sel,
    output logic [CNT_W-1:0]             cnt_value,
    output logic                         irq
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SEL_W = $clog2(NUM_PROPS);

    logic [TS_W-1:0]      stamp;
    logic [NUM_PROPS-1:0] hit;

`ifdef RM_C4_EDGE_DETECT_EN
    logic [NUM_PROPS-1:0] prev_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_flags <= '0;
        end else if (run) begin
            prev_flags <= ltl_flags;
        end
    end

    assign hit = ltl_flags & ~prev_flags & prop_mask & {NUM_PROPS{run}};
`else
    assign hit = ltl_flags & prop_mask & {NUM_PROPS{run}};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp <= '0;
        end else if (run) begin
            stamp <= stamp + TS_W'(1);
        end
    end

    // Event port: a transfer happens on a cycle where evt_valid && evt_ready at the rising edge;
    // evt_valid never depends on evt_ready and the head stays stable until it is taken.
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [TS_W-1:0]      mem_stamp [FIFO_DEPTH];
    logic [NUM_PROPS-1:0] mem_flags [FIFO_DEPTH];
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = |hit;
    assign pop   = evt_valid && evt_ready;
    // When full, a same-cycle pop frees the slot the write lands in, so nothing is lost.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_stamp[wr_ptr[AW-1:0]] <= stamp;
            mem_flags[wr_ptr[AW-1:0]] <= hit;
        end
    end

    assign evt_valid = !empty;
    assign evt_flags = empty ? '0 : mem_flags[rd_ptr[AW-1:0]];
    assign evt_stamp = empty ? '0 : mem_stamp[rd_ptr[AW-1:0]];

    logic [NUM_PROPS-1:0] sticky_next;
    logic                 overflow_next;

    // A hit or drop in the clear cycle wins over the clear.
    assign sticky_next   = (clr_sticky ? '0 : sticky) | hit;
    assign overflow_next = (clr_sticky ? 1'b0 : overflow) | drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky   <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            sticky   <= sticky_next;
            overflow <= overflow_next;
            irq      <= (|sticky_next) | overflow_next;
        end
    end

    logic [CNT_W-1:0] cnt [NUM_PROPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROPS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (hit[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_value = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            if (cnt_sel == SEL_W'(i)) cnt_value = cnt[i];
        end
    end

endmodule

// File: tb/tb_rm_c4_violation_collector.sv
// Self-checking bench for rm_c4_violation_collector: a per-cycle vector table plus directed
// sequences for drain ordering, edge-detect mode and asynchronous mid-stream reset.
module tb_rm_c4_violation_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  ltl_flags;
    logic [6:0]  prop_mask;
    logic        evt_valid;
    logic        evt_ready;
    logic [6:0]  evt_flags;
    logic [31:0] evt_stamp;
    logic [6:0]  sticky;
    logic        overflow;
    logic        clr_sticky;
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_value;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] tb_stamp;
    logic [38:0] exp_q[$];

    always #5 clk = ~clk;

    rm_c4_violation_collector dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ltl_flags  (ltl_flags),
        .prop_mask  (prop_mask),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_flags  (evt_flags),
        .evt_stamp  (evt_stamp),
        .sticky     (sticky),
        .overflow   (overflow),
        .clr_sticky (clr_sticky),
        .cnt_sel    (cnt_sel),
        .cnt_value  (cnt_value),
        .irq        (irq)
    );

    typedef struct {
        logic        run;
        logic [6:0]  flags;
        logic [6:0]  mask;
        logic        ready;
        logic        clr;
        logic [2:0]  sel;
        logic        valid;
        logic [6:0]  eflags;
        logic [31:0] estamp;
        logic [6:0]  sticky;
        logic        ovf;
        logic        irq;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[36];

    function automatic vec_t mk(input logic r, input logic [6:0] f, input logic [6:0] m,
                                input logic rdy, input logic c, input logic [2:0] s,
                                input logic v, input logic [6:0] ef, input logic [31:0] es,
                                input logic [6:0] st, input logic o, input logic q,
                                input logic [15:0] n);
        vec_t t;
        t.run = r; t.flags = f; t.mask = m; t.ready = rdy; t.clr = c; t.sel = s;
        t.valid = v; t.eflags = ef; t.estamp = es; t.sticky = st; t.ovf = o; t.irq = q; t.cnt = n;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 time unit after the next edge.
    task automatic step(input logic r, input logic [6:0] f, input logic [6:0] m,
                        input logic rdy, input logic c, input logic [2:0] s);
        run = r; ltl_flags = f; prop_mask = m; evt_ready = rdy; clr_sticky = c; cnt_sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        run = 1'b0; ltl_flags = '0; prop_mask = 7'h7F; evt_ready = 1'b0; clr_sticky = 1'b0; cnt_sel = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tb_stamp = '0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ltl_flags = '0; prop_mask = 7'h7F;
        evt_ready = 1'b0; clr_sticky = 1'b0; cnt_sel = '0; tb_stamp = '0;
        #2;
        chk("rst evt_valid", 64'(evt_valid), 64'h0);
        chk("rst evt_flags", 64'(evt_flags), 64'h0);
        chk("rst evt_stamp", 64'(evt_stamp), 64'h0);
        chk("rst sticky",    64'(sticky),    64'h0);
        chk("rst overflow",  64'(overflow),  64'h0);
        chk("rst irq",       64'(irq),       64'h0);
        chk("rst cnt",       64'(cnt_value), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifndef RM_C4_EDGE_DETECT_EN
        for (int i = 0; i < 5; i++)
            vecs[i] = mk(1, 7'h00, 7'h7F, 1, 0, 0,  0, 7'h00, 0,  7'h00, 0, 0, 0);
        vecs[5]  = mk(1, 7'h04, 7'h7F, 1, 0, 2,  1, 7'h04, 5,  7'h04, 0, 1, 1);
        vecs[6]  = mk(1, 7'h00, 7'h7F, 1, 0, 2,  0, 7'h00, 0,  7'h04, 0, 1, 1);
        vecs[7]  = mk(1, 7'h00, 7'h7F, 1, 1, 2,  0, 7'h00, 0,  7'h00, 0, 0, 1);
        vecs[8]  = mk(1, 7'h01, 7'h7F, 0, 0, 0,  1, 7'h01, 8,  7'h01, 0, 1, 1);
        vecs[9]  = mk(1, 7'h01, 7'h7F, 0, 0, 0,  1, 7'h01, 8,  7'h01, 0, 1, 2);
        vecs[10] = mk(1, 7'h01, 7'h7F, 0, 0, 0,  1, 7'h01, 8,  7'h01, 0, 1, 3);
        vecs[11] = mk(1, 7'h01, 7'h7F, 0, 0, 0,  1, 7'h01, 8,  7'h01, 0, 1, 4);
        vecs[12] = mk(1, 7'h01, 7'h7F, 0, 0, 0,  1, 7'h01, 8,  7'h01, 1, 1, 5);
        vecs[13] = mk(1, 7'h01, 7'h7F, 0, 0, 0,  1, 7'h01, 8,  7'h01, 1, 1, 6);
        vecs[14] = mk(1, 7'h00, 7'h7F, 1, 0, 0,  1, 7'h01, 9,  7'h01, 1, 1, 6);
        vecs[15] = mk(1, 7'h00, 7'h7F, 1, 0, 0,  1, 7'h01, 10, 7'h01, 1, 1, 6);
        vecs[16] = mk(1, 7'h00, 7'h7F, 1, 0, 0,  1, 7'h01, 11, 7'h01, 1, 1, 6);
        vecs[17] = mk(1, 7'h00, 7'h7F, 1, 0, 0,  0, 7'h00, 0,  7'h01, 1, 1, 6);
        vecs[18] = mk(1, 7'h02, 7'h7F, 0, 1, 1,  1, 7'h02, 18, 7'h02, 0, 1, 1);
        vecs[19] = mk(1, 7'h02, 7'h7F, 0, 0, 1,  1, 7'h02, 18, 7'h02, 0, 1, 2);
        vecs[20] = mk(1, 7'h02, 7'h7F, 0, 0, 1,  1, 7'h02, 18, 7'h02, 0, 1, 3);
        vecs[21] = mk(1, 7'h02, 7'h7F, 0, 0, 1,  1, 7'h02, 18, 7'h02, 0, 1, 4);
        vecs[22] = mk(1, 7'h20, 7'h7F, 1, 0, 5,  1, 7'h02, 19, 7'h22, 0, 1, 1);
        vecs[23] = mk(1, 7'h00, 7'h7F, 1, 0, 5,  1, 7'h02, 20, 7'h22, 0, 1, 1);
        vecs[24] = mk(1, 7'h00, 7'h7F, 1, 0, 5,  1, 7'h02, 21, 7'h22, 0, 1, 1);
        vecs[25] = mk(1, 7'h00, 7'h7F, 1, 0, 5,  1, 7'h20, 22, 7'h22, 0, 1, 1);
        vecs[26] = mk(1, 7'h00, 7'h7F, 1, 0, 5,  0, 7'h00, 0,  7'h22, 0, 1, 1);
        vecs[27] = mk(1, 7'h40, 7'h7F, 1, 1, 6,  1, 7'h40, 27, 7'h40, 0, 1, 1);
        vecs[28] = mk(1, 7'h00, 7'h7F, 1, 1, 6,  0, 7'h00, 0,  7'h00, 0, 0, 1);
        vecs[29] = mk(1, 7'h01, 7'h7E, 1, 0, 0,  0, 7'h00, 0,  7'h00, 0, 0, 6);
        vecs[30] = mk(0, 7'h7F, 7'h7F, 1, 0, 0,  0, 7'h00, 0,  7'h00, 0, 0, 6);
        vecs[31] = mk(0, 7'h7F, 7'h7F, 1, 0, 0,  0, 7'h00, 0,  7'h00, 0, 0, 6);
        vecs[32] = mk(1, 7'h10, 7'h7F, 1, 0, 4,  1, 7'h10, 30, 7'h10, 0, 1, 1);
        vecs[33] = mk(1, 7'h00, 7'h7F, 0, 0, 4,  1, 7'h10, 30, 7'h10, 0, 1, 1);
        vecs[34] = mk(1, 7'h00, 7'h7F, 0, 0, 4,  1, 7'h10, 30, 7'h10, 0, 1, 1);
        vecs[35] = mk(1, 7'h00, 7'h7F, 1, 0, 7,  0, 7'h00, 0,  7'h10, 0, 1, 0);

        for (int i = 0; i < 36; i++) begin
            step(vecs[i].run, vecs[i].flags, vecs[i].mask, vecs[i].ready, vecs[i].clr, vecs[i].sel);
            chk($sformatf("row%0d evt_valid", i), 64'(evt_valid), 64'(vecs[i].valid));
            chk($sformatf("row%0d evt_flags", i), 64'(evt_flags), 64'(vecs[i].eflags));
            chk($sformatf("row%0d evt_stamp", i), 64'(evt_stamp), 64'(vecs[i].estamp));
            chk($sformatf("row%0d sticky", i),    64'(sticky),    64'(vecs[i].sticky));
            chk($sformatf("row%0d overflow", i),  64'(overflow),  64'(vecs[i].ovf));
            chk($sformatf("row%0d irq", i),       64'(irq),       64'(vecs[i].irq));
            chk($sformatf("row%0d cnt_value", i), 64'(cnt_value), 64'(vecs[i].cnt));
        end
`endif

        // Drain ordering against a small stamp model and an expected queue.
        reset_dut();
        exp_q.delete();
        begin
            logic [6:0] seq_flags [3];
            seq_flags[0] = 7'h11; seq_flags[1] = 7'h22; seq_flags[2] = 7'h44;
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back({tb_stamp, seq_flags[i]});
                tb_stamp = tb_stamp + 32'd1;
                step(1, seq_flags[i], 7'h7F, 0, 0, 0);
            end
        end
        begin
            int budget = 8;
            int n = 0;
            while (exp_q.size() > 0) begin
                if (budget == 0) begin
                    chk("drain timeout", 64'(exp_q.size()), 64'h0);
                    break;
                end
                budget--;
                chk($sformatf("drain%0d evt_valid", n), 64'(evt_valid), 64'h1);
                chk($sformatf("drain%0d head", n), 64'({evt_stamp, evt_flags}), 64'(exp_q[0]));
                step(1, 7'h00, 7'h7F, 1, 0, 0);
                void'(exp_q.pop_front());
                n++;
            end
            chk("drain empty", 64'(evt_valid), 64'h0);
        end

`ifdef RM_C4_EDGE_DETECT_EN
        reset_dut();
        repeat (10) step(1, 7'h08, 7'h7F, 0, 0, 3);
        chk("edge cnt3", 64'(cnt_value), 64'h1);
        chk("edge evt_valid", 64'(evt_valid), 64'h1);
        chk("edge evt_flags", 64'(evt_flags), 64'h08);
        chk("edge evt_stamp", 64'(evt_stamp), 64'h0);
        step(1, 7'h08, 7'h7F, 1, 0, 3);
        chk("edge single event", 64'(evt_valid), 64'h0);
        chk("edge cnt3 held", 64'(cnt_value), 64'h1);
        chk("edge sticky", 64'(sticky), 64'h08);
`endif

        // Asynchronous reset in the middle of a cycle with a loaded FIFO and live counters.
        repeat (3) step(1, 7'h7F, 7'h7F, 0, 0, 0);
        chk("pre-rst evt_valid", 64'(evt_valid), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid-rst evt_valid", 64'(evt_valid), 64'h0);
        chk("mid-rst evt_flags", 64'(evt_flags), 64'h0);
        chk("mid-rst evt_stamp", 64'(evt_stamp), 64'h0);
        chk("mid-rst sticky",    64'(sticky),    64'h0);
        chk("mid-rst overflow",  64'(overflow),  64'h0);
        chk("mid-rst irq",       64'(irq),       64'h0);
        for (int i = 0; i < 7; i++) begin
            cnt_sel = 3'(i);
            #1;
            chk($sformatf("mid-rst cnt%0d", i), 64'(cnt_value), 64'h0);
        end
        run = 1'b0;
        ltl_flags = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
